// File: rtl/lifo_pkg.sv
// Shared types and constants for the LIFO pop-burst streamer.
package lifo_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_DRAIN = 2'd2
  } lifo_state_e;

endpackage

// File: rtl/lifo_out_buf.sv
// Two-entry valid/ready skid buffer; the head entry drives the outputs directly
// so data is registered and holds steady while the consumer stalls.
module lifo_out_buf
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             head_v_q;
  logic             skid_v_q;
  logic             out_pop;

  assign out_pop   = head_v_q && out_ready;
  assign out_valid = head_v_q;
  assign out_data  = head_q;
  assign occupancy = OCC_W'(head_v_q) + OCC_W'(skid_v_q);

  // Head refills from the skid entry first, preserving arrival order.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (!head_v_q || out_pop) begin
      if (skid_v_q) begin
        head_q   <= skid_q;
        head_v_q <= 1'b1;
        skid_v_q <= in_valid;
        if (in_valid) skid_q <= in_data;
      end else begin
        head_v_q <= in_valid;
        if (in_valid) head_q <= in_data;
      end
    end else if (in_valid) begin
      skid_q   <= in_data;
      skid_v_q <= 1'b1;
    end
  end

endmodule

// File: rtl/lifo_pop_streamer.sv
// Pops a burst of words from a LIFO (1-cycle read latency) and streams them
// out over valid/ready with a last marker; bursts are truncated to the fill level.
module lifo_pop_streamer
  import lifo_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              cmd_valid_i,
  input  logic [AWIDTH:0]   cmd_len_i,
  output logic              cmd_ready_o,
  output logic              lifo_rdreq_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  input  logic              lifo_empty_i,
  input  logic [AWIDTH:0]   lifo_usedw_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_last_o,
  input  logic              src_ready_i,
  output logic              busy_o,
  output logic              err_short_o
);

  localparam int unsigned LW = AWIDTH + 1;
  localparam int unsigned CW = OCC_W + 1;

  lifo_state_e      state_q, state_d;
  logic [LW-1:0]    remaining_q, remaining_d;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             err_short_q, err_short_d;
  logic             rd_pend_q;
  logic             rd_last_q;
  logic             rdreq_c;

  logic             cmd_accept;
  logic [LW-1:0]    eff_len;
  logic             ds_pop;
  logic [OCC_W-1:0] buf_occ;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    slot_limit;

  assign cmd_accept = cmd_valid_i && cmd_ready_q;
  assign eff_len    = (cmd_len_i < lifo_usedw_i) ? cmd_len_i : lifo_usedw_i;
  assign ds_pop     = src_valid_o && src_ready_i;
  // Words held plus the read in flight must leave room once this cycle's pop frees a slot.
  assign inflight   = CW'(buf_occ) + CW'(rd_pend_q);
  assign slot_limit = CW'(BUF_DEPTH) + CW'(ds_pop);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    err_short_d = 1'b0;
    rdreq_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          err_short_d = eff_len < cmd_len_i;
          if (eff_len != '0) begin
            remaining_d = eff_len;
            state_d     = ST_POP;
          end
        end
      end
      ST_POP: begin
        rdreq_c = (remaining_q != '0) && !lifo_empty_i && (inflight < slot_limit);
        if (rdreq_c) begin
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ds_pop && src_last_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      remaining_q <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_short_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      cmd_ready_q <= state_d == ST_IDLE;
      busy_q      <= state_d != ST_IDLE;
      err_short_q <= err_short_d;
      rd_pend_q   <= rdreq_c;
      rd_last_q   <= rdreq_c && (remaining_q == LW'(1));
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign err_short_o  = err_short_q;
  assign lifo_rdreq_o = rdreq_c;

  lifo_out_buf #(
    .WIDTH(DWIDTH + 1)
  ) u_out_buf (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .in_valid (rd_pend_q),
    .in_data  ({rd_last_q, lifo_q_i}),
    .out_valid(src_valid_o),
    .out_data ({src_last_o, src_data_o}),
    .out_ready(src_ready_i),
    .occupancy(buf_occ)
  );

endmodule

// File: doc/lifo_pop_streamer.md
LIFO_POP_STREAMER -- requirements
Module: lifo_pop_streamer

Interface
REQ-001 Parameter DWIDTH, default 8: data word width, equal to the LIFO DWIDTH.
REQ-002 Parameter AWIDTH, default 4: LIFO address width; LIFO depth is 2**AWIDTH.
REQ-003 clk_i  in  1: single clock; all logic on its rising edge.
REQ-004 srst_i  in  1: reset, asynchronous, active-high.
REQ-005 cmd_valid_i  in  1: pop-burst command request.
REQ-006 cmd_len_i  in  AWIDTH+1: requested word count, 0..2**AWIDTH.
REQ-007 cmd_ready_o  out  1: command accepted on an edge where cmd_valid_i && cmd_ready_o.
REQ-008 lifo_rdreq_o  out  1: LIFO read request; one pop per edge it is high.
REQ-009 lifo_q_i  in  DWIDTH: LIFO read data, valid after the edge that sampled lifo_rdreq_o (1-cycle latency).
REQ-010 lifo_empty_i  in  1: LIFO empty flag.
REQ-011 lifo_usedw_i  in  AWIDTH+1: LIFO fill level.
REQ-012 src_data_o  out  DWIDTH: stream data.
REQ-013 src_valid_o  out  1: stream data valid.
REQ-014 src_last_o  out  1: final word of the current burst; qualified by src_valid_o.
REQ-015 src_ready_i  in  1: downstream accepts a word on an edge where src_valid_o && src_ready_i.
REQ-016 busy_o  out  1: burst in progress (state not IDLE).
REQ-017 err_short_o  out  1: one-cycle pulse when a command is truncated by LIFO fill level.

Function
REQ-018 FSM states IDLE, POP, DRAIN; cmd_ready_o SHALL be 1 only in IDLE (registered).
REQ-019 On accept: effective length = min(cmd_len_i, lifo_usedw_i) sampled on the accept edge; stored in a remaining counter.
REQ-020 If effective length < cmd_len_i, err_short_o SHALL pulse high for exactly the cycle after the accept edge.
REQ-021 Effective length 0 (len 0 or LIFO empty): no reads, no stream output, FSM stays IDLE; err_short_o pulses only if cmd_len_i > 0.
REQ-022 Otherwise IDLE -> POP; POP -> DRAIN when the last read is issued; DRAIN -> IDLE on the edge the last word is accepted downstream.
REQ-023 Output buffer depth 2 words, registered outputs; lifo_rdreq_o = POP && remaining != 0 && !lifo_empty_i && (buffered + outstanding - downstream_pop) < 2.
REQ-024 lifo_rdreq_o SHALL never be high when lifo_empty_i is high; if LIFO empties early the burst still ends only after remaining reaches 0 (external writes may refill).
REQ-025 Latency: with src_ready_i=1, first word valid after the 2nd rising edge following the accept edge; then one word per cycle, no bubbles.
REQ-026 Words SHALL be emitted in pop order (last written first), no loss, no duplication.
REQ-027 While src_valid_o && !src_ready_i, src_data_o and src_last_o SHALL hold stable.
REQ-028 src_last_o high exactly on the word corresponding to the final issued read.
REQ-029 cmd_valid_i while busy is ignored until return to IDLE; a held command is accepted the first IDLE cycle.

Reset
REQ-030 srst_i asserted: immediately FSM=IDLE, counters and buffer cleared, all outputs 0 including cmd_ready_o.
REQ-031 cmd_ready_o SHALL rise on the first edge after srst_i deassertion.
REQ-032 Reset mid-burst discards buffered and outstanding read data; nothing is emitted after reset for the aborted burst.

Structure
REQ-033 Shared package lifo_pkg SHALL hold the FSM state enum and the buffer depth constant (2).
REQ-034 One sub-module lifo_out_buf: 2-entry valid/ready skid buffer with occupancy output; FSM and counters stay in the top.

Verification (DWIDTH=8, AWIDTH=4)
REQ-035 Push 0x11,0x12,0x13,0x14; cmd len 4, ready=1 -> 0x14,0x13,0x12,0x11 on 4 consecutive cycles, first after 2nd edge post-accept, last on 0x11, err_short_o=0.
REQ-036 usedw=3, cmd len 5 -> err_short_o one-cycle pulse, exactly 3 words, src_last_o on 3rd, lifo_empty_i=1 at end.
REQ-037 Full LIFO (16 words), cmd len 16, src_ready_i random 50% -> all 16 in reverse order, data stable under stall, usedw never underflows, rdreq never while empty.
REQ-038 cmd len 0 -> no rdreq, no output, no err; empty LIFO with cmd len 2 -> err pulse, no rdreq, busy_o stays 0.
REQ-039 Reset asserted asynchronously after 3 of 8 words -> all outputs 0 same cycle, cmd_ready_o 1 on first edge after release, no further words.
REQ-040 Second cmd_valid_i held during a burst of 4 -> accepted the cycle after DRAIN->IDLE, its burst follows correctly.
